// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states, grant
// identifiers, data/counter widths and the round-robin winner selection.
package mem_bus_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_t;

  // On a tie the requester that was not granted last wins.
  function automatic gnt_t pick_winner(logic v0, logic v1, gnt_t last);
    if (v0 && v1) return (last == GNT_M1) ? GNT_M0 : GNT_M1;
    return v0 ? GNT_M0 : GNT_M1;
  endfunction

endpackage

// File: rtl/mem_arb_timeout_cnt.sv
// Counts consecutive un-acknowledged BUSY cycles; expired flags the cycle in
// which the count reaches TIMEOUT_CYCLES.
module mem_arb_timeout_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the MEM stage (M0)
// and a debug/loader master (M1), with slave timeout and M0 read flush.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [WORD_W-1:0] m0_addr_i,
  input  logic [WORD_W-1:0] m0_wdata_i,
  output logic [WORD_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [WORD_W-1:0] m1_addr_i,
  input  logic [WORD_W-1:0] m1_wdata_i,
  output logic [WORD_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [WORD_W-1:0] s_addr_o,
  output logic [WORD_W-1:0] s_wdata_o,
  input  logic [WORD_W-1:0] s_rdata_i,
  input  logic              s_ack_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_t        r_state;
  gnt_t              r_gnt;
  gnt_t              r_last;
  logic              r_kill;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err;
  logic              r_s_req;
  logic              r_s_we;
  logic [WORD_W-1:0] r_s_addr;
  logic [WORD_W-1:0] r_s_wdata;
  logic [WORD_W-1:0] r_cap;
  logic [WORD_W-1:0] r_m0_rdata;
  logic [WORD_W-1:0] r_m1_rdata;

  logic w_v0;
  logic w_v1;
  gnt_t w_win;
  logic w_expired;
  logic w_m0_read_flush;
  logic w_m0_ack;

  assign w_v0  = m0_req_i && !flush_i;
  assign w_v1  = m1_req_i;
  assign w_win = pick_winner(w_v0, w_v1, r_last);

  // A flush only cancels the response of an M0 read; writes always complete.
  assign w_m0_read_flush = flush_i && (r_gnt == GNT_M0) && !r_s_we;
  assign w_m0_ack        = r_ack0 && !w_m0_read_flush;

  mem_arb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (r_state != ST_BUSY),
    .en     ((r_state == ST_BUSY) && !s_ack_i),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= GNT_M0;
      r_last     <= GNT_M1;
      r_kill     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_err      <= 1'b0;
      r_s_req    <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_cap      <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err  <= 1'b0;
      if (w_m0_ack) r_m0_rdata <= r_cap;
      case (r_state)
        ST_IDLE: begin
          if (w_v0 || w_v1) begin
            r_gnt     <= w_win;
            r_last    <= w_win;
            r_kill    <= 1'b0;
            r_s_req   <= 1'b1;
            r_s_we    <= (w_win == GNT_M1) ? m1_we_i    : m0_we_i;
            r_s_addr  <= (w_win == GNT_M1) ? m1_addr_i  : m0_addr_i;
            r_s_wdata <= (w_win == GNT_M1) ? m1_wdata_i : m0_wdata_i;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_m0_read_flush) r_kill <= 1'b1;
          // A slave ack in the expiring cycle takes priority over the timeout.
          if (s_ack_i || w_expired) begin
            r_s_req <= 1'b0;
            r_cap   <= s_ack_i ? s_rdata_i : '0;
            r_err   <= !s_ack_i;
            r_ack0  <= (r_gnt == GNT_M0) && !r_kill && !w_m0_read_flush;
            r_ack1  <= (r_gnt == GNT_M1);
            if (r_gnt == GNT_M1) r_m1_rdata <= s_ack_i ? s_rdata_i : '0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack_o   = w_m0_ack;
  assign m0_rdata_o = w_m0_ack ? r_cap : r_m0_rdata;
  assign m1_ack_o   = r_ack1;
  assign m1_rdata_o = r_m1_rdata;
  assign s_req_o    = r_s_req;
  assign s_we_o     = r_s_we;
  assign s_addr_o   = r_s_addr;
  assign s_wdata_o  = r_s_wdata;
  assign err_o      = r_err;
  assign stall_o    = m0_req_i && !w_m0_ack && !flush_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m1_ack_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i, flush_i, stall_o, err_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
    .flush_i(flush_i), .stall_o(stall_o), .err_o(err_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one outstanding transaction plus committed read data.
  bit          md_open, md_rsp, md_who, md_we, md_last1, md_kill, md_err;
  logic [31:0] md_addr, md_wdata, md_data, md_rd0, md_rd1;
  int          md_wait;
  bit          last_a0, last_a1, last_flush;

  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_open = 0; md_rsp = 0; md_who = 0; md_we = 0; md_last1 = 1;
    md_kill = 0; md_err = 0; md_wait = 0;
    md_addr = '0; md_wdata = '0; md_data = '0; md_rd0 = '0; md_rd1 = '0;
  endtask

  task automatic compare_and_advance();
    bit e_a0, e_a1, r0, r1;
    logic [31:0] e_rd0, e_rd1;
    e_a0  = md_rsp && !md_who && !md_kill && !(flush_i && !md_we);
    e_a1  = md_rsp && md_who;
    e_rd0 = e_a0 ? md_data : md_rd0;
    e_rd1 = e_a1 ? md_data : md_rd1;
    chk1("s_req", s_req_o, md_open);
    chk1("s_we", s_we_o, md_we);
    chk32("s_addr", s_addr_o, md_addr);
    chk32("s_wdata", s_wdata_o, md_wdata);
    chk1("m0_ack", m0_ack_o, e_a0);
    chk1("m1_ack", m1_ack_o, e_a1);
    chk32("m0_rdata", m0_rdata_o, e_rd0);
    chk32("m1_rdata", m1_rdata_o, e_rd1);
    chk1("err", err_o, md_rsp && md_err);
    chk1("stall", stall_o, m0_req_i && !e_a0 && !flush_i);
    last_a0 = m0_ack_o; last_a1 = m1_ack_o; last_flush = flush_i;
    if (!rst_n) begin
      model_reset();
    end else if (md_rsp) begin
      if (e_a0) md_rd0 = md_data;
      if (e_a1) md_rd1 = md_data;
      md_rsp = 0;
    end else if (md_open) begin
      if (flush_i && !md_who && !md_we) md_kill = 1;
      if (s_ack_i) begin
        md_data = s_rdata_i; md_err = 0; md_rsp = 1; md_open = 0;
      end else begin
        md_wait++;
        if (md_wait == T) begin
          md_data = '0; md_err = 1; md_rsp = 1; md_open = 0;
        end
      end
    end else begin
      r0 = m0_req_i && !flush_i;
      r1 = m1_req_i;
      if (r0 || r1) begin
        md_who   = (r0 && r1) ? !md_last1 : r1;
        md_last1 = md_who;
        md_we    = md_who ? m1_we_i    : m0_we_i;
        md_addr  = md_who ? m1_addr_i  : m0_addr_i;
        md_wdata = md_who ? m1_wdata_i : m0_wdata_i;
        md_open = 1; md_kill = 0; md_wait = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_pct;
    rst_n = 0; m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
    s_rdata_i = 0; s_ack_i = 0; flush_i = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    #1;
    chk1("rst_s_req", s_req_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk32("rst_s_addr", s_addr_o, 32'h0);
    chk32("rst_m1_rdata", m1_rdata_o, 32'h0);

    // M0 read, slave acks in the first BUSY cycle.
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h0000_0100; #1;
    chk1("r32_stall0", stall_o, 1'b1);
    step();
    chk32("r32_s_addr", s_addr_o, 32'h0000_0100);
    s_ack_i = 1; s_rdata_i = 32'h1234_5678; #1;
    chk1("r32_stall1", stall_o, 1'b1);
    step();
    s_ack_i = 0; #1;
    chk1("r32_ack", m0_ack_o, 1'b1);
    chk32("r32_rdata", m0_rdata_o, 32'h1234_5678);
    chk1("r32_stall2", stall_o, 1'b0);
    step();
    m0_req_i = 0; step();

    // Tie after reset: M0, then M1 three cycles later, then M0 again.
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h200;
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h300; m1_wdata_i = 32'hBEEF;
    step();
    chk32("tie1_addr", s_addr_o, 32'h200);
    s_ack_i = 1; step();
    s_ack_i = 0; #1;
    chk1("tie1_m0ack", m0_ack_o, 1'b1);
    step();
    m0_req_i = 0; step();
    chk1("tie2_sreq", s_req_o, 1'b1);
    chk32("tie2_addr", s_addr_o, 32'h300);
    s_ack_i = 1; step();
    s_ack_i = 0; #1;
    chk1("tie2_m1ack", m1_ack_o, 1'b1);
    step();
    m0_req_i = 1; m0_addr_i = 32'h204; m1_addr_i = 32'h304; step();
    chk32("tie3_addr", s_addr_o, 32'h204);
    s_ack_i = 1; step();
    s_ack_i = 0; step();
    m0_req_i = 0; m1_req_i = 0; step();

    // Slave never acks: timeout after T BUSY cycles.
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h400; step();
    for (int i = 0; i < T; i++) begin
      chk1("to_sreq", s_req_o, 1'b1);
      step();
    end
    chk1("to_ack", m0_ack_o, 1'b1);
    chk1("to_err", err_o, 1'b1);
    chk32("to_rdata", m0_rdata_o, 32'h0);
    chk1("to_sreq_low", s_req_o, 1'b0);
    step();
    m0_req_i = 0; step();

    // Ack arrives in the cycle the count would expire: ack wins.
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h500; step();
    step(); step(); step();
    s_ack_i = 1; s_rdata_i = 32'h5A5A_5A5A; step();
    s_ack_i = 0; #1;
    chk1("race_ack", m1_ack_o, 1'b1);
    chk1("race_err", err_o, 1'b0);
    chk32("race_rdata", m1_rdata_o, 32'h5A5A_5A5A);
    step();
    m1_req_i = 0; step();

    // Flushed M0 read is suppressed; flushed M0 write still acks.
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h600; step();
    flush_i = 1; s_ack_i = 1; s_rdata_i = 32'hAAAA_5555; step();
    flush_i = 0; s_ack_i = 0; m0_req_i = 0; #1;
    chk1("fl_rd_ack", m0_ack_o, 1'b0);
    chk32("fl_rd_rdata", m0_rdata_o, 32'h0);
    step(); step();
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h700; m0_wdata_i = 32'hCAFE; step();
    flush_i = 1; s_ack_i = 1; step();
    flush_i = 0; s_ack_i = 0; #1;
    chk1("fl_wr_ack", m0_ack_o, 1'b1);
    step();
    m0_req_i = 0; m0_we_i = 0; step();

    // Reset mid-BUSY of an M1 write.
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h800; m1_wdata_i = 32'h1; step();
    chk1("rb_sreq", s_req_o, 1'b1);
    rst_n = 0; step();
    rst_n = 1; m1_req_i = 0; #1;
    chk1("rb_sreq0", s_req_o, 1'b0);
    chk1("rb_ack", m1_ack_o, 1'b0);
    chk1("rb_err", err_o, 1'b0);
    step(); step();

    // Random traffic under protocol-following masters and a lazy slave.
    ack_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ack_pct = (ack_pct == 70) ? 12 : 70;
      if (m0_req_i && last_a0) begin
        if ($urandom_range(3) == 0) begin
          m0_we_i = 1'($urandom_range(1)); m0_addr_i = $urandom; m0_wdata_i = $urandom;
        end else m0_req_i = 0;
      end else if (m0_req_i && last_flush && !m0_we_i && $urandom_range(1) == 1) begin
        m0_req_i = 0;
      end else if (!m0_req_i && $urandom_range(4) < 2) begin
        m0_req_i = 1; m0_we_i = 1'($urandom_range(1));
        m0_addr_i = $urandom; m0_wdata_i = $urandom;
      end
      if (m1_req_i && last_a1) begin
        if ($urandom_range(3) == 0) begin
          m1_we_i = 1'($urandom_range(1)); m1_addr_i = $urandom; m1_wdata_i = $urandom;
        end else m1_req_i = 0;
      end else if (!m1_req_i && $urandom_range(4) < 2) begin
        m1_req_i = 1; m1_we_i = 1'($urandom_range(1));
        m1_addr_i = $urandom; m1_wdata_i = $urandom;
      end
      flush_i   = ($urandom_range(6) == 0);
      s_ack_i   = s_req_o && ($urandom_range(99) < ack_pct);
      s_rdata_i = $urandom;
      rst_n     = ($urandom_range(399) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
